// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - MIPS IF stage: PC, req/ack instruction fetch, small instruction buffer
// Redirects on decode-resolved branches; DROP swallows the ack of an abandoned request.
module if_fetch_stage #(
  parameter int                  WORD_LEN  = 32,
  parameter logic [WORD_LEN-1:0] RESET_PC  = '0,
  parameter int                  BUF_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                freeze,
  input  logic                branch_taken,
  input  logic [WORD_LEN-1:0] branch_offset,
  input  logic [WORD_LEN-1:0] id_pc,
  output logic                imem_req,
  output logic [WORD_LEN-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [WORD_LEN-1:0] imem_rdata,
  output logic                valid_out,
  output logic [WORD_LEN-1:0] instruction_out,
  output logic [WORD_LEN-1:0] pc_out
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] DEPTH = OCC_W'(BUF_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DROP} state_t;

  state_t              state;
  logic [WORD_LEN-1:0] fetch_pc;
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    wr_ptr;
  logic [OCC_W-1:0]    occ;
  logic [OCC_W-1:0]    occ_next;
  logic [WORD_LEN-1:0] pc_buf    [BUF_DEPTH];
  logic [WORD_LEN-1:0] instr_buf [BUF_DEPTH];
  logic                empty;
  logic                push;
  logic                pop;
  logic                has_room;
  logic [WORD_LEN-1:0] target;

  assign imem_addr = fetch_pc;
  assign empty     = (occ == '0);
  assign valid_out = !empty && !branch_taken;
  assign pop       = valid_out && !freeze;
  // Data returned together with a branch is on the wrong path and never enters the buffer.
  assign push      = (state == FETCH) && imem_ack && !branch_taken;
  assign occ_next  = occ + OCC_W'(push) - OCC_W'(pop);
  assign has_room  = (occ_next < DEPTH);
  assign target    = id_pc + (branch_offset << 2);

  assign instruction_out = empty ? '0 : instr_buf[rd_ptr];
  assign pc_out          = empty ? '0 : pc_buf[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      pc_buf[wr_ptr]    <= fetch_pc + WORD_LEN'(4);
      instr_buf[wr_ptr] <= imem_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      imem_req <= 1'b0;
      fetch_pc <= RESET_PC;
      occ      <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      occ <= occ_next;

      if (branch_taken) begin
        occ      <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        fetch_pc <= target;
      end else if (push) begin
        fetch_pc <= fetch_pc + WORD_LEN'(4);
      end

      case (state)
        IDLE: begin
          if (!branch_taken && has_room) begin
            state    <= FETCH;
            imem_req <= 1'b1;
          end
        end
        FETCH: begin
          if (branch_taken) begin
            // An unanswered request is still owed an ack; DROP waits for and discards it.
            state    <= imem_ack ? IDLE : DROP;
            imem_req <= !imem_ack;
          end else if (imem_ack && !has_room) begin
            state    <= IDLE;
            imem_req <= 1'b0;
          end
        end
        DROP: begin
          if (imem_ack) begin
            state    <= IDLE;
            imem_req <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - self-checking bench for if_fetch_stage
// Memory model returns the request address as data; a queue holds the expected instruction stream.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_offset = '0;
  logic [31:0] id_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        valid_out;
  logic [31:0] instruction_out;
  logic [31:0] pc_out;

  if_fetch_stage #(.WORD_LEN(32), .RESET_PC(32'h0), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .id_pc(id_pc), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .valid_out(valid_out), .instruction_out(instruction_out), .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int pops = 0;

  // Variable-latency memory: ack after lat cycles of req, data = address latched at request start.
  int          lat = 1;
  int          cnt = 0;
  logic [31:0] mem_addr = '0;
  always @(negedge clk) begin
    if (rst || !imem_req) begin
      imem_ack = 1'b0;
      cnt = 0;
    end else begin
      if (cnt == 0) mem_addr = imem_addr;
      if (cnt == lat - 1) begin
        imem_ack = 1'b1;
        imem_rdata = mem_addr;
        cnt = 0;
      end else begin
        imem_ack = 1'b0;
        cnt = cnt + 1;
      end
    end
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic        fr;
    logic        br;
    logic [31:0] off;
    logic [31:0] idpc;
    logic        ev;
    logic        er;
    logic [31:0] ea;
  } vec_t;
  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
    end
  endtask

  task automatic refill(input logic [31:0] start);
    logic [31:0] a;
    exp_t e;
    exp_q.delete();
    a = start;
    for (int i = 0; i < 40; i++) begin
      e.pc = a + 32'd4;
      e.instr = a;
      exp_q.push_back(e);
      a = a + 32'd4;
    end
  endtask

  // Called at posedge+1; drives one cycle, samples at negedge+1, returns at next posedge+1.
  task automatic run_cycle(input logic fr, input logic br, input logic [31:0] off,
                           input logic [31:0] idpc, output logic sv, output logic sr,
                           output logic [31:0] sa);
    exp_t e;
    freeze = fr;
    branch_taken = br;
    branch_offset = off;
    id_pc = idpc;
    if (br) refill(idpc + (off << 2));
    @(negedge clk);
    #1;
    sv = valid_out;
    sr = imem_req;
    sa = imem_addr;
    if (valid_out) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = exp_q[0];
        chk("sb_pc_out", pc_out, e.pc);
        chk("sb_instr", instruction_out, e.instr);
        if (!fr) begin
          void'(exp_q.pop_front());
          pops++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic fr, input logic br, input logic [31:0] off,
                     input logic [31:0] idpc, input logic ev, input logic er,
                     input logic [31:0] ea);
    vec_t v;
    v.fr = fr; v.br = br; v.off = off; v.idpc = idpc;
    v.ev = ev; v.er = er; v.ea = ea;
    vq.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        sv, sr;
    logic [31:0] sa;
    int          n;
    int          pops_before;

    // Stream from reset, 5-cycle freeze with full buffer, branch from IDLE, branch on ack with wrap.
    add(0, 0, 0, 0, 0, 0, 32'h00);
    add(0, 0, 0, 0, 0, 1, 32'h00);
    add(0, 0, 0, 0, 1, 1, 32'h04);
    add(0, 0, 0, 0, 1, 1, 32'h08);
    add(0, 0, 0, 0, 1, 1, 32'h0C);
    add(1, 0, 0, 0, 1, 1, 32'h10);
    add(1, 0, 0, 0, 1, 0, 32'h14);
    add(1, 0, 0, 0, 1, 0, 32'h14);
    add(1, 0, 0, 0, 1, 0, 32'h14);
    add(1, 0, 0, 0, 1, 0, 32'h14);
    add(0, 0, 0, 0, 1, 0, 32'h14);
    add(0, 0, 0, 0, 1, 1, 32'h14);
    add(0, 0, 0, 0, 1, 1, 32'h18);
    add(1, 0, 0, 0, 1, 1, 32'h1C);
    add(1, 0, 0, 0, 1, 0, 32'h20);
    add(0, 1, 32'h3, 32'h40, 0, 0, 32'h20);
    add(0, 0, 0, 0, 0, 0, 32'h4C);
    add(0, 0, 0, 0, 0, 1, 32'h4C);
    add(0, 0, 0, 0, 1, 1, 32'h50);
    add(0, 0, 0, 0, 1, 1, 32'h54);
    add(0, 1, 32'hFFFF_FFFF, 32'h0, 0, 1, 32'h58);
    add(0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC);
    add(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    add(0, 0, 0, 0, 1, 1, 32'h00);
    add(0, 0, 0, 0, 1, 1, 32'h04);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_req", {31'b0, imem_req}, 32'd0);
    chk("reset_valid", {31'b0, valid_out}, 32'd0);
    chk("reset_instr", instruction_out, 32'd0);
    chk("reset_pc_out", pc_out, 32'd0);
    rst = 1'b0;
    refill(32'h0);

    for (int i = 0; i < vq.size(); i++) begin
      run_cycle(vq[i].fr, vq[i].br, vq[i].off, vq[i].idpc, sv, sr, sa);
      chk($sformatf("vec%0d_valid", i), {31'b0, sv}, {31'b0, vq[i].ev});
      chk($sformatf("vec%0d_req", i), {31'b0, sr}, {31'b0, vq[i].er});
      chk($sformatf("vec%0d_addr", i), sa, vq[i].ea);
    end

    // Branch while a 3-cycle request to 0x10 is outstanding.
    rst = 1'b1;
    #1;
    lat = 3;
    @(posedge clk);
    #1;
    rst = 1'b0;
    refill(32'h0);
    n = 0;
    while (!(imem_req && imem_addr == 32'h10) && n < 200) begin
      run_cycle(0, 0, 0, 0, sv, sr, sa);
      n++;
    end
    chk("drop_reach_0x10", {31'b0, (n < 200)}, 32'd1);
    run_cycle(0, 0, 0, 0, sv, sr, sa);
    run_cycle(0, 1, 32'h4, 32'h100, sv, sr, sa);
    chk("drop_valid_on_branch", {31'b0, sv}, 32'd0);
    chk("drop_req_held", {31'b0, imem_req}, 32'd1);
    chk("drop_addr_target", imem_addr, 32'h110);
    run_cycle(0, 0, 0, 0, sv, sr, sa);
    chk("drop_stale_valid", {31'b0, valid_out}, 32'd0);
    chk("drop_idle_req", {31'b0, imem_req}, 32'd0);
    run_cycle(0, 0, 0, 0, sv, sr, sa);
    chk("drop_refetch_req", {31'b0, imem_req}, 32'd1);
    chk("drop_refetch_addr", imem_addr, 32'h110);
    pops_before = pops;
    repeat (8) run_cycle(0, 0, 0, 0, sv, sr, sa);
    chk("drop_resumed", {31'b0, (pops > pops_before)}, 32'd1);

    // Asynchronous reset in the middle of FETCH.
    lat = 1;
    repeat (3) run_cycle(0, 0, 0, 0, sv, sr, sa);
    chk("midrst_pre_req", {31'b0, imem_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_req", {31'b0, imem_req}, 32'd0);
    chk("midrst_valid", {31'b0, valid_out}, 32'd0);
    chk("midrst_instr", instruction_out, 32'd0);
    chk("midrst_pc_out", pc_out, 32'd0);
    @(posedge clk);
    #1;
    chk("midrst_addr", imem_addr, 32'h0);
    rst = 1'b0;
    refill(32'h0);
    run_cycle(0, 0, 0, 0, sv, sr, sa);
    chk("restart_req", {31'b0, imem_req}, 32'd1);
    chk("restart_addr", imem_addr, 32'h0);
    run_cycle(0, 0, 0, 0, sv, sr, sa);
    chk("restart_first_valid", {31'b0, valid_out}, 32'd1);
    chk("restart_first_pc", pc_out, 32'h4);
    pops_before = pops;
    repeat (4) run_cycle(0, 0, 0, 0, sv, sr, sa);
    chk("restart_stream", pops - pops_before, 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
